pulse_qualifier: RTL and testbench

Glitch-rejecting input qualifier: synchronises an asynchronous single-bit input into `clk` and accepts a level change only once the new level has been stable for 2^WIDTH consecutive sampled cycles. It is the receive-side counterpart to the pulse extender. It consumes stretched, slow or bouncing level signals from off-chip or cross-domain sources, for example status lines from the FX2LP or a DAC. It produces a clean registered level plus single-cycle rise and fall event strobes for the control logic.

---
 rtl/pulse_qualifier.sv | 117 +++++++++++
 tb/tb_pulse_qualifier.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_qualifier.sv
// pulse_qualifier: synchronises an asynchronous level and accepts a change
// only after it has been stable for 2^WIDTH consecutive sampled cycles.
// Produces a registered qualified level plus single-cycle rise/fall strobes.
module pulse_qualifier #(
  parameter int unsigned WIDTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall
);

  typedef enum logic [1:0] {
    LOW      = 2'd0,
    RISE_CHK = 2'd1,
    HIGH     = 2'd2,
    FALL_CHK = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] count_plus_one;
  logic             s1_q, s2_q;
  logic             out_q, out_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // Two-flop synchroniser; the FSM only ever looks at s2_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= in;
      s2_q <= s1_q;
    end
  end

  // FSM state, stability counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOW;
      count_q <= '0;
      out_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Next-state logic: a reversion during a check aborts it and drops all credit.
  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    out_d          = out_q;
    rise_d         = 1'b0;
    fall_d         = 1'b0;
    count_plus_one = count_q + WIDTH'(1);
    case (state_q)
      LOW: begin
        if (s2_q) begin
          state_d = RISE_CHK;
          count_d = WIDTH'(1);
        end
      end
      RISE_CHK: begin
        if (!s2_q) begin
          state_d = LOW;
          count_d = '0;
        end else if (count_plus_one == '0) begin
          state_d = HIGH;
          count_d = '0;
          out_d   = 1'b1;
          rise_d  = 1'b1;
        end else begin
          count_d = count_plus_one;
        end
      end
      HIGH: begin
        if (!s2_q) begin
          state_d = FALL_CHK;
          count_d = WIDTH'(1);
        end
      end
      FALL_CHK: begin
        if (s2_q) begin
          state_d = HIGH;
          count_d = '0;
        end else if (count_plus_one == '0) begin
          state_d = LOW;
          count_d = '0;
          out_d   = 1'b0;
          fall_d  = 1'b1;
        end else begin
          count_d = count_plus_one;
        end
      end
      default: begin
        state_d = LOW;
        count_d = '0;
        out_d   = 1'b0;
      end
    endcase
  end

  assign out  = out_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: tb/tb_pulse_qualifier.sv
// Directed bench for pulse_qualifier: WIDTH=4 and WIDTH=1 instances share
// clock and reset; inputs change 1 ns after a rising edge and outputs are
// observed at that same point, so tick i observes the state after edge i.
module tb_pulse_qualifier;

  logic clk;
  logic rst_n;
  logic in4, out4, rise4, fall4;
  logic in1, out1, rise1, fall1;

  int vectors;
  int miscompares;

  pulse_qualifier #(.WIDTH(4)) u_w4 (
    .clk  (clk),
    .rst_n(rst_n),
    .in   (in4),
    .out  (out4),
    .rise (rise4),
    .fall (fall4)
  );

  pulse_qualifier #(.WIDTH(1)) u_w1 (
    .clk  (clk),
    .rst_n(rst_n),
    .in   (in1),
    .out  (out1),
    .rise (rise1),
    .fall (fall1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in4   = 1'b0;
    in1   = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Input high through reset; expect a single rise 17 edges after the first post-reset edge.
  task automatic test_reset();
    int rises, falls, first;
    rst_n = 1'b0;
    in4   = 1'b1;
    in1   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({out4, rise4, fall4} !== 3'b000) begin
        miscompares++;
        $display("FAIL reset_hold: out/rise/fall=%b required 000", {out4, rise4, fall4});
      end
    end
    rst_n = 1'b1;
    rises = 0; falls = 0; first = -1;
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (rise4) begin rises++; if (first < 0) first = i; end
      if (fall4) falls++;
    end
    vectors++;
    if (rises !== 1 || falls !== 0) begin
      miscompares++;
      $display("FAIL reset_release_count: rises=%0d falls=%0d required 1 0", rises, falls);
    end
    vectors++;
    if (first !== 18) begin
      miscompares++;
      $display("FAIL reset_release_latency: rise at tick %0d required 18", first);
    end
    vectors++;
    if (out4 !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_out: out=%b required 1", out4);
    end
    // Asynchronous reset while HIGH must clear out immediately without a strobe.
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({out4, rise4, fall4} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_async_clear: out/rise/fall=%b required 000", {out4, rise4, fall4});
    end
    in4 = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Clean 0->1 then 1->0 steps; each strobe one cycle, 17 edges after capture.
  task automatic test_clean_edge();
    int rises, falls, first_r, first_f, rise_len;
    do_reset();
    in4 = 1'b1;
    rises = 0; falls = 0; first_r = -1; first_f = -1; rise_len = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (rise4) begin rises++; rise_len++; if (first_r < 0) first_r = i; end
      if (fall4) begin falls++; if (first_f < 0) first_f = i; end
      if (rise4 && fall4) begin
        miscompares++;
        $display("FAIL clean_both_strobes: rise=1 fall=1 at tick %0d required not both", i);
      end
      if (i == 18) begin
        vectors++;
        if (out4 !== 1'b1) begin
          miscompares++;
          $display("FAIL clean_out_high: out=%b required 1", out4);
        end
      end
      if (i == 17) begin
        vectors++;
        if (out4 !== 1'b0) begin
          miscompares++;
          $display("FAIL clean_out_early: out=%b required 0", out4);
        end
      end
      if (i == 30) in4 = 1'b0;
    end
    vectors++;
    if (first_r !== 18 || rise_len !== 1) begin
      miscompares++;
      $display("FAIL clean_rise: first=%0d len=%0d required 18 1", first_r, rise_len);
    end
    vectors++;
    if (first_f !== 48 || falls !== 1) begin
      miscompares++;
      $display("FAIL clean_fall: first=%0d count=%0d required 48 1", first_f, falls);
    end
    vectors++;
    if (out4 !== 1'b0) begin
      miscompares++;
      $display("FAIL clean_out_final: out=%b required 0", out4);
    end
  endtask

  // 15-cycle pulse is rejected; 16-cycle pulse qualifies (then falls back).
  task automatic test_glitch();
    int rises, falls, first;
    do_reset();
    in4 = 1'b1;
    rises = 0; falls = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (rise4) rises++;
      if (fall4) falls++;
      if (out4 !== 1'b0) rises += 100;
      if (i == 15) in4 = 1'b0;
    end
    vectors++;
    if (rises !== 0 || falls !== 0) begin
      miscompares++;
      $display("FAIL glitch_15_rejected: rise_metric=%0d falls=%0d required 0 0", rises, falls);
    end
    in4 = 1'b1;
    rises = 0; falls = 0; first = -1;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (rise4) begin rises++; if (first < 0) first = i; end
      if (fall4) falls++;
      if (i == 16) in4 = 1'b0;
    end
    vectors++;
    if (rises !== 1 || first !== 18) begin
      miscompares++;
      $display("FAIL glitch_16_accepted: rises=%0d first=%0d required 1 18", rises, first);
    end
    vectors++;
    if (falls !== 1 || out4 !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_16_return: falls=%0d out=%b required 1 0", falls, out4);
    end
  endtask

  // Bounce every 3 cycles for 40 cycles, then hold high.
  task automatic test_bounce();
    int rises, falls, first;
    do_reset();
    in4 = 1'b1;
    rises = 0; falls = 0; first = -1;
    for (int i = 1; i <= 70; i++) begin
      tick();
      if (rise4) begin rises++; if (first < 0) first = i; end
      if (fall4) falls++;
      if (i < 40 && (i % 3) == 0) in4 = ~in4;
      if (i == 40) in4 = 1'b1;
    end
    vectors++;
    if (rises !== 1 || falls !== 0) begin
      miscompares++;
      $display("FAIL bounce_strobes: rises=%0d falls=%0d required 1 0", rises, falls);
    end
    vectors++;
    if (first !== 58) begin
      miscompares++;
      $display("FAIL bounce_latency: rise at tick %0d required 58", first);
    end
  endtask

  // Reset 10 cycles into RISE_CHK; qualification must restart from scratch.
  task automatic test_mid_reset();
    int rises, first;
    do_reset();
    in4 = 1'b1;
    rises = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (rise4) rises++;
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({out4, rise4, fall4} !== 3'b000 || rises !== 0) begin
      miscompares++;
      $display("FAIL midreset_clear: out/rise/fall=%b early_rises=%0d required 000 0",
               {out4, rise4, fall4}, rises);
    end
    tick();
    tick();
    rst_n = 1'b1;
    rises = 0; first = -1;
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (rise4) begin rises++; if (first < 0) first = i; end
    end
    vectors++;
    if (rises !== 1 || first !== 18) begin
      miscompares++;
      $display("FAIL midreset_restart: rises=%0d first=%0d required 1 18", rises, first);
    end
  endtask

  // WIDTH=1: 1-sample pulse rejected, 2-sample pulse accepted 3 edges after capture.
  task automatic test_width1();
    int rises, falls, first_r, first_f;
    do_reset();
    in1 = 1'b1;
    rises = 0; falls = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (rise1 || out1) rises++;
      if (fall1) falls++;
      if (i == 1) in1 = 1'b0;
    end
    vectors++;
    if (rises !== 0 || falls !== 0) begin
      miscompares++;
      $display("FAIL w1_pulse1_rejected: rise_metric=%0d falls=%0d required 0 0", rises, falls);
    end
    in1 = 1'b1;
    rises = 0; falls = 0; first_r = -1; first_f = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (rise1) begin rises++; if (first_r < 0) first_r = i; end
      if (fall1) begin falls++; if (first_f < 0) first_f = i; end
      if (i == 2) in1 = 1'b0;
    end
    vectors++;
    if (rises !== 1 || first_r !== 4) begin
      miscompares++;
      $display("FAIL w1_pulse2_accepted: rises=%0d first=%0d required 1 4", rises, first_r);
    end
    vectors++;
    if (falls !== 1 || first_f !== 6) begin
      miscompares++;
      $display("FAIL w1_pulse2_fall: falls=%0d first=%0d required 1 6", falls, first_f);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in4         = 1'b0;
    in1         = 1'b0;
    test_reset();
    test_clean_edge();
    test_glitch();
    test_bounce();
    test_mid_reset();
    test_width1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
